// File: rtl/req_send_pkg.sv
// req_send_pkg: shared types, defaults and the channel-index width helper for req_send_ctrl
package req_send_pkg;

    typedef enum logic {IDLE, REQ} state_e;

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_CNT_W  = 16;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/req_send_rr_arb.sv
// req_send_rr_arb: picks the first busy channel at or after rr_ptr, wrapping modulo NUM_CH
module req_send_rr_arb
    import req_send_pkg::*;
#(
    parameter int  NUM_CH = DEF_NUM_CH,
    localparam int CH_W   = ch_width(NUM_CH)
) (
    input  logic [NUM_CH-1:0] busy_i,
    input  logic [CH_W-1:0]   rr_ptr_i,
    output logic [CH_W-1:0]   grant_o,
    output logic              grant_vld_o
);

    logic [CH_W-1:0] idx;

    // scan from the farthest offset down so the nearest busy channel wins
    always_comb begin
        grant_o     = '0;
        grant_vld_o = 1'b0;
        idx         = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = CH_W'((int'(rr_ptr_i) + k) % NUM_CH);
            if (busy_i[idx]) begin
                grant_o     = idx;
                grant_vld_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/req_send_ctrl.sv
// req_send_ctrl: per-channel edge capture, round-robin send over one req/ack port; REQ_SEND_TIMEOUT_EN adds the timeout
module req_send_ctrl
    import req_send_pkg::*;
#(
    parameter int  NUM_CH = DEF_NUM_CH,
    parameter int  DATA_W = DEF_DATA_W,
    parameter int  CNT_W  = DEF_CNT_W,
    localparam int CH_W   = ch_width(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [CNT_W-1:0]         max_count,
    input  logic [NUM_CH-1:0]        req_data,
    input  logic [NUM_CH*DATA_W-1:0] data,
    output logic [NUM_CH-1:0]        busy,
    output logic [NUM_CH-1:0]        drop,
    output logic                     req,
    output logic [DATA_W-1:0]        q,
    output logic [CH_W-1:0]          q_ch,
    input  logic                     ack,
    output logic                     done,
    output logic [CH_W-1:0]          done_ch,
    output logic                     timeout
);

    state_e            state_q, state_d;
    logic [NUM_CH-1:0] prev_q, busy_q, busy_d, drop_q, drop_d, rise;
    logic [DATA_W-1:0] word_q [NUM_CH];
    logic [DATA_W-1:0] word_d [NUM_CH];
    logic [DATA_W-1:0] q_q, q_d;
    logic [CH_W-1:0]   q_ch_q, q_ch_d, done_ch_q, done_ch_d, rr_q, rr_d, gnt;
    logic              gnt_vld, done_q, done_d, to_hit, fin, grant_now;

    req_send_rr_arb #(.NUM_CH(NUM_CH)) u_arb (
        .busy_i     (busy_q),
        .rr_ptr_i   (rr_q),
        .grant_o    (gnt),
        .grant_vld_o(gnt_vld)
    );

    assign rise      = req_data & ~prev_q;
    assign grant_now = state_q == IDLE && gnt_vld;
    assign fin       = state_q == REQ && (ack || to_hit);

`ifdef REQ_SEND_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, lim_q;
    logic             timeout_q;

    // lim tracks max_count while idle so it holds the value seen at grant; cnt saturates
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            lim_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= (state_q == IDLE) ? '0 : (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
            lim_q     <= (state_q == IDLE) ? max_count : lim_q;
            timeout_q <= state_q == REQ && !ack && to_hit;
        end
    end

    assign to_hit  = lim_q != '0 && cnt_q == lim_q - CNT_W'(1);
    assign timeout = timeout_q;
`else
    logic unused_max_count;
    assign unused_max_count = ^max_count;
    assign to_hit           = 1'b0;
    assign timeout          = 1'b0;
`endif

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // next state: grant when anything is pending, release on ack or timeout
    always_comb state_d = (state_q == IDLE) ? (gnt_vld ? REQ : IDLE) : (fin ? IDLE : REQ);

    // outputs: load word on grant, report completion, advance the round-robin pointer
    always_comb begin
        done_d    = state_q == REQ && ack;
        done_ch_d = fin ? q_ch_q : done_ch_q;
        q_ch_d    = grant_now ? gnt : q_ch_q;
        q_d       = grant_now ? word_q[gnt] : q_q;
        rr_d      = fin ? ((q_ch_q == CH_W'(NUM_CH - 1)) ? '0 : q_ch_q + CH_W'(1)) : rr_q;
    end

    // capture: a clear at this edge frees the channel first, so a coincident rise recaptures
    always_comb begin
        busy_d = busy_q;
        drop_d = '0;
        word_d = word_q;
        if (fin) busy_d[q_ch_q] = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rise[i] && busy_d[i]) drop_d[i] = 1'b1;
            else if (rise[i]) begin
                busy_d[i] = 1'b1;
                word_d[i] = data[i*DATA_W +: DATA_W];
            end
        end
    end

    // datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q    <= '0;
            busy_q    <= '0;
            drop_q    <= '0;
            word_q    <= '{default: '0};
            q_q       <= '0;
            q_ch_q    <= '0;
            done_q    <= 1'b0;
            done_ch_q <= '0;
            rr_q      <= '0;
        end else begin
            prev_q    <= req_data;
            busy_q    <= busy_d;
            drop_q    <= drop_d;
            word_q    <= word_d;
            q_q       <= q_d;
            q_ch_q    <= q_ch_d;
            done_q    <= done_d;
            done_ch_q <= done_ch_d;
            rr_q      <= rr_d;
        end
    end

    assign busy    = busy_q;
    assign drop    = drop_q;
    assign req     = state_q == REQ;
    assign q       = q_q;
    assign q_ch    = q_ch_q;
    assign done    = done_q;
    assign done_ch = done_ch_q;

endmodule

// File: tb/tb_req_send_ctrl.sv
// tb_req_send_ctrl: scenario tasks plus randomized rounds checked against a transaction-level round-robin model
module tb_req_send_ctrl;

    localparam int N = 4;
    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [15:0]   max_count = '0;
    logic [N-1:0]  req_data = '0;
    logic [N*W-1:0] data = '0;
    logic          ack = 1'b0;
    logic [N-1:0]  busy, drop;
    logic          req, done, timeout;
    logic [W-1:0]  q;
    logic [1:0]    q_ch, done_ch;
    int            checks = 0;
    int            failures = 0;

    always #5 clk = ~clk;

    req_send_ctrl dut (
        .clk(clk), .rst_n(rst_n), .max_count(max_count), .req_data(req_data), .data(data),
        .busy(busy), .drop(drop), .req(req), .q(q), .q_ch(q_ch), .ack(ack),
        .done(done), .done_ch(done_ch), .timeout(timeout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int pick(input logic [N-1:0] pend, input int ptr);
        for (int k = 0; k < N; k++) if (pend[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; req_data = '0; ack = 1'b0; max_count = '0; data = '0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_req(input string nm);
        int n = 0;
        while (req !== 1'b1 && n < 50) begin tick(); n++; end
        checks++;
        if (req !== 1'b1) begin failures++; $display("FAIL %s_req: req=%b want 1", nm, req); end
    endtask

    task automatic serve(input string nm, input logic [1:0] ch, input logic [W-1:0] w, input int dly);
        wait_req(nm);
        checks++;
        if (q_ch !== ch || q !== w) begin
            failures++; $display("FAIL %s_grant: q_ch=%0d q=%h want q_ch=%0d q=%h", nm, q_ch, q, ch, w);
        end
        repeat (dly) begin
            tick();
            checks++;
            if (req !== 1'b1) begin failures++; $display("FAIL %s_hold: req=%b want 1", nm, req); end
        end
        ack = 1'b1; tick(); ack = 1'b0;
        checks++;
        if (done !== 1'b1 || done_ch !== ch || req !== 1'b0 || busy[ch] !== 1'b0 || timeout !== 1'b0) begin
            failures++;
            $display("FAIL %s_done: done=%b done_ch=%0d req=%b busy=%b timeout=%b want 1 %0d 0 busy[ch]=0 0",
                     nm, done, done_ch, req, busy, timeout, ch);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        checks++;
        if ({busy, drop, req, q, q_ch, done, done_ch, timeout} !== '0) begin
            failures++;
            $display("FAIL reset: busy=%b drop=%b req=%b q=%h q_ch=%0d done=%b done_ch=%0d timeout=%b want all 0",
                     busy, drop, req, q, q_ch, done, done_ch, timeout);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        data[2*W +: W] = 16'hA5A5; req_data[2] = 1'b1;
        tick();
        checks++;
        if (busy !== 4'b0100 || req !== 1'b0) begin failures++; $display("FAIL single_capture: busy=%b req=%b want 0100 0", busy, req); end
        tick();
        checks++;
        if (req !== 1'b1 || q !== 16'hA5A5 || q_ch !== 2'd2) begin
            failures++; $display("FAIL single_grant: req=%b q=%h q_ch=%0d want 1 a5a5 2", req, q, q_ch);
        end
        tick(); tick();
        checks++;
        if (req !== 1'b1) begin failures++; $display("FAIL single_hold: req=%b want 1", req); end
        ack = 1'b1; tick(); ack = 1'b0;
        checks++;
        if (done !== 1'b1 || done_ch !== 2'd2 || req !== 1'b0 || busy !== 4'b0000 || q !== 16'hA5A5 || q_ch !== 2'd2) begin
            failures++;
            $display("FAIL single_done: done=%b done_ch=%0d req=%b busy=%b q=%h q_ch=%0d want 1 2 0 0000 a5a5 2",
                     done, done_ch, req, busy, q, q_ch);
        end
        req_data = '0;
        tick();
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL single_pulse: done=%b want 0", done); end
    endtask

    task automatic test_round_robin();
        logic [W-1:0] w [N];
        int order [3] = '{0, 1, 3};
        do_reset();
        for (int i = 0; i < N; i++) begin w[i] = W'($urandom); data[i*W +: W] = w[i]; end
        req_data = 4'b1011;
        tick();
        checks++;
        if (busy !== 4'b1011) begin failures++; $display("FAIL rr_capture: busy=%b want 1011", busy); end
        for (int i = 0; i < 3; i++) begin
            serve("rr", 2'(order[i]), w[order[i]], 0);
            if (i < 2) begin
                tick();
                checks++;
                if (req !== 1'b1) begin failures++; $display("FAIL rr_gap: req=%b want 1 after one idle cycle", req); end
            end
        end
        req_data = '0;
        tick();
    endtask

    task automatic test_timeout();
        int ch, n, mc;
        logic bad;
`ifdef REQ_SEND_TIMEOUT_EN
        ch = $urandom_range(0, N - 1);
        max_count = 16'd5; data[ch*W +: W] = W'($urandom); req_data[ch] = 1'b1;
        wait_req("to5");
        n = 0;
        while (req === 1'b1 && n < 200) begin n++; tick(); end
        checks++;
        if (n != 5 || timeout !== 1'b1 || done !== 1'b0 || done_ch !== 2'(ch) || busy[ch] !== 1'b0) begin
            failures++;
            $display("FAIL to5: req_cycles=%0d timeout=%b done=%b done_ch=%0d busy=%b want 5 1 0 %0d busy[ch]=0",
                     n, timeout, done, done_ch, busy, ch);
        end
        tick();
        checks++;
        if (timeout !== 1'b0) begin failures++; $display("FAIL to5_pulse: timeout=%b want 0", timeout); end
        req_data = '0;
        tick();
        mc = 0;
`else
        mc = 5;
`endif
        ch = $urandom_range(0, N - 1);
        max_count = 16'(mc); data[ch*W +: W] = W'($urandom); req_data[ch] = 1'b1;
        wait_req("hold");
        bad = 1'b0;
        repeat (100) begin tick(); if (req !== 1'b1 || timeout !== 1'b0) bad = 1'b1; end
        checks++;
        if (bad !== 1'b0) begin failures++; $display("FAIL hold100: req dropped or timeout fired, req=%b timeout=%b want 1 0", req, timeout); end
        ack = 1'b1; tick(); ack = 1'b0;
        checks++;
        if (done !== 1'b1 || done_ch !== 2'(ch)) begin failures++; $display("FAIL hold_done: done=%b done_ch=%0d want 1 %0d", done, done_ch, ch); end
        req_data = '0; max_count = '0;
        tick();
    endtask

    task automatic test_ack_last();
        int ch = $urandom_range(0, N - 1);
        max_count = 16'd3; data[ch*W +: W] = W'($urandom); req_data[ch] = 1'b1;
        wait_req("acklast");
        tick(); tick();
        checks++;
        if (req !== 1'b1) begin failures++; $display("FAIL acklast_hold: req=%b want 1", req); end
        ack = 1'b1; tick(); ack = 1'b0;
        checks++;
        if (done !== 1'b1 || timeout !== 1'b0 || done_ch !== 2'(ch)) begin
            failures++; $display("FAIL acklast: done=%b timeout=%b done_ch=%0d want 1 0 %0d", done, timeout, done_ch, ch);
        end
        req_data = '0; max_count = '0;
        tick();
        checks++;
        if (timeout !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL acklast_after: done=%b timeout=%b want 0 0", done, timeout); end
    endtask

    task automatic test_drop_recapture();
        logic [W-1:0] w1, w2, w3;
        w1 = W'($urandom); w2 = ~w1; w3 = w1 + 16'd1;
        data[W +: W] = w1; req_data[1] = 1'b1;
        tick();
        checks++;
        if (busy[1] !== 1'b1) begin failures++; $display("FAIL drop_cap: busy=%b want busy[1]=1", busy); end
        req_data[1] = 1'b0;
        tick();
        data[W +: W] = w2; req_data[1] = 1'b1;
        tick();
        checks++;
        if (drop !== 4'b0010 || q !== w1 || req !== 1'b1) begin
            failures++; $display("FAIL drop_pulse: drop=%b q=%h req=%b want 0010 %h 1", drop, q, req, w1);
        end
        tick();
        checks++;
        if (drop !== 4'b0000) begin failures++; $display("FAIL drop_clear: drop=%b want 0000", drop); end
        req_data[1] = 1'b0;
        tick();
        data[W +: W] = w3; req_data[1] = 1'b1; ack = 1'b1;
        tick();
        ack = 1'b0;
        checks++;
        if (done !== 1'b1 || done_ch !== 2'd1 || busy[1] !== 1'b1 || drop !== 4'b0000 || q !== w1) begin
            failures++;
            $display("FAIL recap_done: done=%b done_ch=%0d busy=%b drop=%b q=%h want 1 1 busy[1]=1 0000 %h",
                     done, done_ch, busy, drop, q, w1);
        end
        tick();
        checks++;
        if (req !== 1'b1 || q !== w3 || q_ch !== 2'd1) begin
            failures++; $display("FAIL recap_grant: req=%b q=%h q_ch=%0d want 1 %h 1", req, q, q_ch, w3);
        end
        ack = 1'b1; tick(); ack = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 4'b0000) begin failures++; $display("FAIL recap_end: done=%b busy=%b want 1 0000", done, busy); end
        req_data = '0;
        tick();
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] w = W'($urandom);
        data[0 +: W] = w; req_data[0] = 1'b1;
        wait_req("rstmid");
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, drop, req, q, q_ch, done, done_ch, timeout} !== '0) begin
            failures++;
            $display("FAIL rst_async: busy=%b drop=%b req=%b q=%h q_ch=%0d done=%b done_ch=%0d timeout=%b want all 0",
                     busy, drop, req, q, q_ch, done, done_ch, timeout);
        end
        tick(); tick();
        #2 rst_n = 1'b1;
        tick();
        checks++;
        if (busy !== 4'b0001 || req !== 1'b0) begin failures++; $display("FAIL rst_recapture: busy=%b req=%b want 0001 0", busy, req); end
        serve("rst_serve", 2'd0, w, 0);
        req_data = '0;
        tick();
    endtask

    task automatic test_random();
        logic [W-1:0] w [N];
        logic [N-1:0] mask, pend;
        int ptr, ch;
        do_reset();
        ptr = 0;
        repeat (12) begin
            mask = N'($urandom_range(1, 15));
            for (int i = 0; i < N; i++) begin w[i] = W'($urandom); data[i*W +: W] = w[i]; end
            req_data = mask;
            tick();
            checks++;
            if (busy !== mask) begin failures++; $display("FAIL rand_capture: busy=%b want %b", busy, mask); end
            pend = mask;
            while (pend != '0) begin
                ch = pick(pend, ptr);
                serve("rand", 2'(ch), w[ch], $urandom_range(0, 3));
                pend[ch] = 1'b0;
                ptr = (ch + 1) % N;
            end
            req_data = '0;
            tick();
            checks++;
            if (busy !== '0 || drop !== '0 || req !== 1'b0) begin
                failures++; $display("FAIL rand_idle: busy=%b drop=%b req=%b want 0 0 0", busy, drop, req);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_ack_last();
        test_drop_recapture();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
